// File: rtl/decode_hazard_scoreboard.sv
// decode_hazard_scoreboard
//
// Decode-stage issue controller. Tracks in-flight register writes with a
// small counter per register (32 scalar + 32 vector), holds the decode
// instruction until its sources are safe to read and its destination has
// room for another pending write, and implements a drain/idle handshake
// used to halt the pipeline.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 decode holds a valid instruction
//   id_rs1/id_rs2            source indices; *_en = source read, *_vec = vector file
//   id_rd                    destination index
//   id_wr_scalar/id_wr_vec   instruction writes scalar / vector file
//   flush                    kill the decode instruction this cycle
//   wb_rd                    write-back destination index
//   wb_wr_scalar/wb_wr_vec   write-back retires a scalar / vector write
//   drain_req                stop issuing and wait for the pipeline to empty
//   issue                    decode instruction advances this cycle
//   stall                    hold fetch/decode registers
//   idle                     drain complete, nothing pending
//   err                      sticky: retire seen with no matching pending write
//   stall_cycles             saturating count of stall cycles
//
// Build option
//   WB_BYPASS_EN  when defined, a source whose last pending write is being
//                 retired this cycle is treated as ready (needs a
//                 write-through register file).

module decode_hazard_scoreboard #(
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_rs1_en,
  input  logic                   id_rs2_en,
  input  logic                   id_rs1_vec,
  input  logic                   id_rs2_vec,
  input  logic [4:0]             id_rd,
  input  logic                   id_wr_scalar,
  input  logic                   id_wr_vec,
  input  logic                   flush,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_wr_scalar,
  input  logic                   wb_wr_vec,
  input  logic                   drain_req,
  output logic                   issue,
  output logic                   stall,
  output logic                   idle,
  output logic                   err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] sc_cnt  [32];
  logic [CNT_W-1:0] vc_cnt  [32];
  logic [CNT_W-1:0] sc_next [32];
  logic [CNT_W-1:0] vc_next [32];

  state_t state, state_next;

  logic [CNT_W-1:0] rs1_entry, rs2_entry;
  logic             rs1_busy, rs2_busy, waw_block, ready;
  logic             underflow, tables_empty_next;

  // Saturation is never reached on increment because the WAW check blocks
  // issue at the maximum count; decrement of zero is reported separately.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec)
      return cnt + CNT_ONE;
    if (dec && !inc && (cnt != '0))
      return cnt - CNT_ONE;
    return cnt;
  endfunction

  assign rs1_entry = id_rs1_vec ? vc_cnt[id_rs1] : sc_cnt[id_rs1];
  assign rs2_entry = id_rs2_vec ? vc_cnt[id_rs2] : sc_cnt[id_rs2];

`ifdef WB_BYPASS_EN
  // The last outstanding write to a source is landing this cycle through a
  // write-through register file, so the source can be read right now.
  logic rs1_retiring, rs2_retiring;
  assign rs1_retiring = (wb_rd == id_rs1) && (id_rs1_vec ? wb_wr_vec : wb_wr_scalar);
  assign rs2_retiring = (wb_rd == id_rs2) && (id_rs2_vec ? wb_wr_vec : wb_wr_scalar);
  assign rs1_busy = id_rs1_en && (rs1_entry != '0) && !((rs1_entry == CNT_ONE) && rs1_retiring);
  assign rs2_busy = id_rs2_en && (rs2_entry != '0) && !((rs2_entry == CNT_ONE) && rs2_retiring);
`else
  assign rs1_busy = id_rs1_en && (rs1_entry != '0);
  assign rs2_busy = id_rs2_en && (rs2_entry != '0);
`endif

  assign waw_block = (id_wr_scalar && (sc_cnt[id_rd] == CNT_MAX)) ||
                     (id_wr_vec    && (vc_cnt[id_rd] == CNT_MAX));

  assign ready = id_valid && !flush && !rs1_busy && !rs2_busy && !waw_block;

  // Handshake outputs; all forced low while reset is held.
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    idle  = 1'b0;
    if (!rst) begin
      issue = ready && (state == RUN);
      stall = id_valid && !flush && !issue;
      idle  = (state == IDLE);
    end
  end

  // Next values of both counter tables. An issue and a retire hitting the
  // same entry cancel out; a retire with nothing pending raises underflow.
  always_comb begin
    tables_empty_next = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sc_next[i] = step_cnt(sc_cnt[i],
                            issue && id_wr_scalar && (id_rd == 5'(i)),
                            wb_wr_scalar && (wb_rd == 5'(i)));
      vc_next[i] = step_cnt(vc_cnt[i],
                            issue && id_wr_vec && (id_rd == 5'(i)),
                            wb_wr_vec && (wb_rd == 5'(i)));
      if ((sc_next[i] != '0) || (vc_next[i] != '0))
        tables_empty_next = 1'b0;
    end
    underflow = (wb_wr_scalar && (sc_cnt[wb_rd] == '0) &&
                 !(issue && id_wr_scalar && (id_rd == wb_rd))) ||
                (wb_wr_vec    && (vc_cnt[wb_rd] == '0) &&
                 !(issue && id_wr_vec    && (id_rd == wb_rd)));
  end

  // Drain sequencing. Dropping drain_req during DRAIN returns to RUN even
  // if the tables happen to empty in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (drain_req) state_next = DRAIN;
      DRAIN:   if (!drain_req) state_next = RUN;
               else if (tables_empty_next) state_next = IDLE;
      IDLE:    if (!drain_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State, counter tables, sticky error flag and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      err          <= 1'b0;
      stall_cycles <= '0;
      for (int i = 0; i < 32; i++) begin
        sc_cnt[i] <= '0;
        vc_cnt[i] <= '0;
      end
    end else begin
      state  <= state_next;
      sc_cnt <= sc_next;
      vc_cnt <= vc_next;
      if (underflow)
        err <= 1'b1;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// tb_decode_hazard_scoreboard
//
// Testbench for decode_hazard_scoreboard. Each scenario task drives a list
// of one-cycle steps; the expected {issue, stall, idle} of each step is
// queued when the step is driven and popped and compared at the following
// falling edge. Sticky/statistics outputs are checked inline at chosen
// points. Expectations depend on whether WB_BYPASS_EN is defined.

module tb_decode_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_rs1_en, id_rs2_en, id_rs1_vec, id_rs2_vec;
  logic        id_wr_scalar, id_wr_vec, flush;
  logic        wb_wr_scalar, wb_wr_vec, drain_req;
  logic        issue, stall, idle, err;
  logic [15:0] stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  // Outcome of reading a register in the cycle its last write retires.
  localparam logic [2:0] RETIRE_READ = BYPASS ? 3'b100 : 3'b010;

  // One cycle of stimulus: a single source (on rs1, or on rs2 with rs1
  // pointing at the same register but disabled), plus expected
  // {issue, stall, idle}.
  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       rs_en;
    logic       rs_vec;
    logic       use_rs2;
    logic [4:0] rd;
    logic       wr_s;
    logic       wr_v;
    logic       flush;
    logic [4:0] wb_rd;
    logic       wb_s;
    logic       wb_v;
    logic       drain;
    logic [2:0] exp;
  } step_t;

  logic [2:0] exp_q[$];

  decode_hazard_scoreboard #(.CNT_W(2), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rs1_vec(id_rs1_vec), .id_rs2_vec(id_rs2_vec),
    .id_rd(id_rd), .id_wr_scalar(id_wr_scalar), .id_wr_vec(id_wr_vec),
    .flush(flush), .wb_rd(wb_rd), .wb_wr_scalar(wb_wr_scalar), .wb_wr_vec(wb_wr_vec),
    .drain_req(drain_req), .issue(issue), .stall(stall), .idle(idle),
    .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_step(input step_t s);
    @(posedge clk); #1;
    id_valid     = s.v;
    id_rs1       = s.rs;
    id_rs2       = s.rs;
    id_rs1_en    = s.rs_en && !s.use_rs2;
    id_rs2_en    = s.rs_en && s.use_rs2;
    id_rs1_vec   = s.rs_vec;
    id_rs2_vec   = s.rs_vec;
    id_rd        = s.rd;
    id_wr_scalar = s.wr_s;
    id_wr_vec    = s.wr_v;
    flush        = s.flush;
    wb_rd        = s.wb_rd;
    wb_wr_scalar = s.wb_s;
    wb_wr_vec    = s.wb_v;
    drain_req    = s.drain;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [2:0] e;
    rst = 1'b1; id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_rs1_en = 1'b1; id_rs2_en = 1'b0; id_rs1_vec = 1'b0; id_rs2_vec = 1'b0;
    id_rd = 5'd1; id_wr_scalar = 1'b1; id_wr_vec = 1'b0; flush = 1'b0;
    wb_rd = 5'd0; wb_wr_scalar = 1'b0; wb_wr_vec = 1'b0; drain_req = 1'b0;
    exp_q.push_back(3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({issue, stall, idle} !== e) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: issue/stall/idle got %b%b%b want %b", issue, stall, idle, e);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_err: got %b want 0", err);
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
    @(posedge clk); #1;
    rst = 1'b0; id_valid = 1'b0; id_wr_scalar = 1'b0; id_rs1_en = 1'b0;
  endtask

  task automatic test_raw_scalar();
    step_t s[$];
    logic [2:0] e;
    s.push_back('{1,0,0,0,0, 5,1,0,0, 0,0,0,0, 3'b100});  // write r5
    s.push_back('{1,5,1,0,0, 0,0,0,0, 0,0,0,0, 3'b010});  // read r5 on rs1
    s.push_back('{1,5,1,0,1, 0,0,0,0, 0,0,0,0, 3'b010});  // read r5 on rs2
    s.push_back('{1,5,1,0,0, 0,0,0,0, 5,1,0,0, RETIRE_READ});
    s.push_back('{1,5,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL raw step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
    end
    n_cmp++;
    if (stall_cycles !== (BYPASS ? 16'd2 : 16'd3)) begin
      n_fail++;
      $display("[TB] FAIL raw_stall_cycles: got %0d want %0d", stall_cycles, BYPASS ? 2 : 3);
    end
  endtask

  task automatic test_bypass();
    step_t s[$];
    logic [2:0] e;
    s.push_back('{1,0,0,0,0, 5,1,1,0, 0,0,0,0, 3'b100});  // write r5 and v5
    s.push_back('{1,5,1,0,0, 0,0,0,0, 5,0,1,0, 3'b010});  // read r5, v5 retires
    s.push_back('{1,5,1,0,0, 0,0,0,0, 5,1,0,0, RETIRE_READ});
    s.push_back('{1,5,1,1,1, 0,0,0,0, 0,0,0,0, 3'b100});  // read v5 on rs2
    s.push_back('{1,5,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});  // r5 back to 0
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL bypass step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
    end
  endtask

  task automatic test_waw_files();
    step_t s[$];
    logic [2:0] e;
    repeat (3) s.push_back('{1,0,0,0,0, 3,0,1,0, 0,0,0,0, 3'b100});  // v3 x3
    s.push_back('{1,0,0,0,0, 3,0,1,0, 0,0,0,0, 3'b010});  // v3 full
    s.push_back('{1,3,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});  // scalar r3 free
    s.push_back('{1,0,0,0,0, 3,0,1,0, 3,0,1,0, 3'b010});  // retire cycle
    s.push_back('{1,0,0,0,0, 3,0,1,0, 0,0,0,0, 3'b100});  // now fits
    s.push_back('{1,3,1,1,0, 0,0,0,0, 0,0,0,0, 3'b010});  // read v3 busy
    repeat (3) s.push_back('{0,0,0,0,0, 0,0,0,0, 3,0,1,0, 3'b000});
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL waw step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    logic [2:0] e;
    s.push_back('{1,0,0,0,0, 7,1,0,0, 0,0,0,0, 3'b100});  // r7 -> 1
    s.push_back('{1,0,0,0,0, 7,1,0,0, 7,1,0,0, 3'b100});  // +1 -1, stays 1
    s.push_back('{1,7,1,0,0, 0,0,0,0, 0,0,0,0, 3'b010});  // nonzero
    s.push_back('{0,0,0,0,0, 0,0,0,0, 7,1,0,0, 3'b000});  // 1 -> 0
    s.push_back('{1,7,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});  // free again
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL simul step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL simul_err: got %b want 0", err);
    end
  endtask

  task automatic test_drain();
    step_t s[$];
    logic [2:0] e;
    s.push_back('{1,0,0,0,0, 1,1,0,0, 0,0,0,0, 3'b100});  // write r1
    s.push_back('{1,0,0,0,0, 2,0,1,0, 0,0,0,0, 3'b100});  // write v2
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b000});  // -> DRAIN
    s.push_back('{1,0,0,0,0, 4,1,0,0, 0,0,0,1, 3'b010});  // blocked
    s.push_back('{0,0,0,0,0, 0,0,0,0, 1,1,0,1, 3'b000});  // retire r1
    s.push_back('{0,0,0,0,0, 0,0,0,0, 2,0,1,1, 3'b000});  // retire v2
    s.push_back('{1,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b011});  // IDLE
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0, 3'b001});  // release
    s.push_back('{1,0,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});  // RUN again
    s.push_back('{1,0,0,0,0, 1,1,0,0, 0,0,0,0, 3'b100});  // write r1
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b000});  // -> DRAIN
    s.push_back('{1,2,1,0,0, 0,0,0,0, 0,0,0,0, 3'b010});  // abort drain
    s.push_back('{1,2,1,0,0, 0,0,0,0, 0,0,0,0, 3'b100});  // RUN
    s.push_back('{0,0,0,0,0, 0,0,0,0, 1,1,0,0, 3'b000});  // retire r1
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL drain step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
    end
  endtask

  task automatic test_underflow_flush_reset();
    step_t s[$];
    logic [2:0] e;
    s.push_back('{0,0,0,0,0, 0,0,0,0, 9,1,0,0, 3'b000});  // underflow r9
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0, 3'b000});
    s.push_back('{1,0,0,0,0, 8,1,0,1, 0,0,0,0, 3'b000});  // flushed
    s.push_back('{1,0,0,0,0, 8,1,0,1, 0,0,0,1, 3'b000});  // flush + drain
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b000});  // DRAIN
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b001});  // IDLE: no r8 write
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0, 3'b001});
    s.push_back('{1,0,0,0,0, 6,1,0,0, 0,0,0,0, 3'b100});  // write r6
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b000});  // -> DRAIN
    s.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,1, 3'b000});  // held by r6
    foreach (s[i]) begin
      apply_step(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({issue, stall, idle} !== e) begin
        n_fail++;
        $display("[TB] FAIL underflow step %0d: issue/stall/idle got %b%b%b want %b", i, issue, stall, idle, e);
      end
      if (i == 1 || i == 9) begin
        n_cmp++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL err_sticky step %0d: got %b want 1", i, err);
        end
      end
    end
    // Reset mid-drain with a valid reader of the pending register.
    @(posedge clk); #1;
    rst = 1'b1; id_valid = 1'b1; id_rs1 = 5'd6; id_rs1_en = 1'b1; id_rs1_vec = 1'b0;
    drain_req = 1'b0;
    exp_q.push_back(3'b000);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({issue, stall, idle} !== e) begin
      n_fail++;
      $display("[TB] FAIL rst_forced: issue/stall/idle got %b%b%b want %b", issue, stall, idle, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(3'b100);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({issue, stall, idle} !== e) begin
      n_fail++;
      $display("[TB] FAIL rst_cleared: issue/stall/idle got %b%b%b want %b", issue, stall, idle, e);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_err: got %b want 0", err);
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_stall_cycles: got %0d want 0", stall_cycles);
    end
    @(posedge clk); #1;
    id_valid = 1'b0; id_rs1_en = 1'b0;
  endtask

  initial begin
    $display("[TB] start, WB_BYPASS_EN=%0d", BYPASS);
    test_reset();
    test_raw_scalar();
    test_bypass();
    test_waw_files();
    test_simultaneous();
    test_drain();
    test_underflow_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_hazard_scoreboard.md
# decode_hazard_scoreboard

Issue controller for the decode stage. It keeps a per-register count of in-flight writes for the 32 scalar and 32 vector registers, and blocks an instruction in decode until its source operands are safe to read. It also arbitrates the decode→execute hand-off against the write-back retire stream and supports a drain/idle sequence for halting the pipeline. It sits beside the decode stage, taking the control unit's register-write flags and the write-back write-enables.

## Interface
Parameters:
- CNT_W, 2: width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W−1.
- STALL_CNT_W, 16: width of the stall-cycle statistics counter.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_valid  in  1  the decode stage holds a valid instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_rs1_en, id_rs2_en  in  1 each  the source is actually read.
- id_rs1_vec, id_rs2_vec  in  1 each  the source is in the vector file (0 = scalar file).
- id_rd  in  5  destination register index.
- id_wr_scalar, id_wr_vec  in  1 each  the instruction writes the scalar or vector file (the control unit's WriteRegister / WriteRegisterVec).
- flush  in  1  a branch was taken; kill the decode instruction this cycle.
- wb_rd  in  5  write-back destination index.
- wb_wr_scalar, wb_wr_vec  in  1 each  write-back is retiring a write (the WB-stage register write-enables).
- drain_req  in  1  stop issuing and wait for the pipeline to empty.
- issue  out  1  the decode instruction advances into execute this cycle.
- stall  out  1  hold the fetch/decode registers.
- idle  out  1  drain is complete and no writes are pending.
- err  out  1  sticky flag: a write-back retire arrived with no matching pending write.
- stall_cycles  out  STALL_CNT_W  count of stall cycles, saturating.

## Operation
- Two counter tables, sc_cnt[0:31] and vc_cnt[0:31], each entry CNT_W wide.
- A source is **busy** when it is enabled and its table entry is nonzero. The write-back bypass exception is described under Configuration.
- **WAW block:** the destination entry is at its maximum count while the instruction writes that file.
- Ready condition: id_valid && !flush && no busy source && no WAW block.
- Outputs:
  - issue = ready && state==RUN.
  - stall = id_valid && !flush && !issue.
  - A flushed instruction neither issues nor stalls.
- Counter update each cycle, applied to both tables independently:
  - +1 on issue for rd in the written file.
  - −1 on write-back retire for wb_rd.
  - When both hit the same entry in the same cycle, the entry is unchanged.
  - If both id_wr_scalar and id_wr_vec are set, both tables are updated.
- Underflow: a retire to an entry that is 0 leaves it at 0 and sets err. err clears only on rst.
- stall_cycles increments every cycle stall=1 and saturates at all-ones.
- Register 0 gets no special treatment.
- State machine:
  - RUN → DRAIN when drain_req=1.
  - DRAIN → IDLE when every entry in both tables is 0 after this cycle's update.
  - IDLE → RUN when drain_req=0.
  - DRAIN → RUN when drain_req drops before IDLE is reached.
  - In DRAIN and IDLE, issue=0. stall follows its normal equation, so it is 1 whenever id_valid is set.
  - idle = (state==IDLE).

## Timing
- issue and stall are combinational from the current inputs and registered state, with zero latency.
- Counters, state, err and stall_cycles update on the clock edge.
- Reset, while rst=1 and on the first edge after it:
  - All counters 0, state RUN, err 0, stall_cycles 0.
  - issue, stall and idle forced to 0 regardless of inputs.
- A write-back retire lowers its entry at the next edge, so a dependent instruction can issue one cycle after the retire cycle.
- Asserting rst mid-drain returns the block to RUN with empty tables. In-flight instructions must be flushed externally.
- flush and drain_req together: flush wins for the current instruction, and the state moves to DRAIN.

## Configuration
- WB_BYPASS_EN defined:
  - A source whose entry equals 1 and which is being retired this cycle by a matching write-back (same index and file) is not busy.
  - The instruction issues in the retire cycle, which requires a write-through register file.
- Not defined: any nonzero entry is busy.

## Test plan
- Scalar RAW, no bypass:
  - Issue a write to scalar r5.
  - Next cycle, an instruction reads r5.
  - Required: stall=1 until the cycle after wb_wr_scalar with wb_rd=5, then issue=1.
  - stall_cycles equals the number of stalled cycles.
- Bypass, with WB_BYPASS_EN:
  - sc_cnt[5]=1, and in the same cycle an instruction reads r5 while wb_rd=5 retires.
  - Required: issue=1 that cycle and sc_cnt[5] ends at 0.
- File separation and WAW saturation:
  - Issue three writes to vector v3 (CNT_W=2).
  - Required: a fourth write to v3 stalls; a read of scalar r3 issues.
  - One retire of v3 lets the fourth write issue on the next cycle.
- Simultaneous increment and decrement:
  - Issue a write to r7 in the same cycle r7 retires from count 1.
  - Required: the count stays 1.
- Drain:
  - Assert drain_req with two writes outstanding.
  - Required: issue=0 while they are outstanding; idle=1 the cycle after the last retire.
  - Deassert drain_req: state returns to RUN.
- Underflow, flush and reset:
  - Retire r9 with count 0 → err=1 and stays set.
  - flush with a valid instruction → issue=0 and stall=0.
  - rst → err=0, idle=0, all counters 0.
